// File: rtl/serial_shift_ctrl.sv
// Sequencer for a universal shift register: runs SLL/SRL/SRA as one parallel
// load, then shamt single-bit shifts, then captures the register output.
module serial_shift_ctrl #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   operand,
    input  logic [SHW-1:0] shamt,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result,
    output logic [N-1:0]   sr_I,
    output logic           sr_bit,
    output logic [1:0]     sr_S,
    input  logic [N-1:0]   sr_Q
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        SHIFT   = 2'b10,
        CAPTURE = 2'b11
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    state_t         state;
    state_t         next_state;
    logic [SHW-1:0] count;
    logic [1:0]     op_q;
    logic [N-1:0]   operand_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture, shift counting and result capture; done marks the cycle after CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            op_q      <= '0;
            operand_q <= '0;
            result    <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == CAPTURE);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        count     <= shamt;
                        operand_q <= operand;
                    end
                end
                SHIFT:   count  <= count - SHW'(1);
                CAPTURE: result <= sr_Q;
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = (count != '0) ? SHIFT : CAPTURE;
            SHIFT:   if (count == SHW'(1)) next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Mode select depends only on registered state so start never reaches sr_S.
    always_comb begin
        sr_S   = MODE_HOLD;
        sr_bit = 1'b0;
        case (state)
            LOAD: sr_S = MODE_LOAD;
            SHIFT: begin
                case (op_q)
                    OP_SLL: sr_S = MODE_LEFT;
                    OP_SRL: sr_S = MODE_RIGHT;
                    OP_SRA: begin
                        sr_S   = MODE_RIGHT;
                        sr_bit = sr_Q[N-1];
                    end
                    default: sr_S = MODE_HOLD;
                endcase
            end
            default: sr_S = MODE_HOLD;
        endcase
    end

    assign sr_I = operand_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Bench for serial_shift_ctrl: drives it against a behavioural shift register and
// compares each result, latency and mode-select profile with an arithmetic model.
module tb_serial_shift_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] sr_I;
    logic        sr_bit;
    logic [1:0]  sr_S;
    logic [31:0] sr_Q;
    logic [31:0] sr_reg;

    int checks;
    int failures;

    serial_shift_ctrl #(.N(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
        .shamt(shamt), .busy(busy), .done(done), .result(result),
        .sr_I(sr_I), .sr_bit(sr_bit), .sr_S(sr_S), .sr_Q(sr_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register the controller drives (no reset, as in hardware).
    always_ff @(posedge clk) begin
        case (sr_S)
            2'b01:   sr_reg <= {sr_reg[30:0], sr_bit};
            2'b10:   sr_reg <= {sr_bit, sr_reg[31:1]};
            2'b11:   sr_reg <= sr_I;
            default: sr_reg <= sr_reg;
        endcase
    end
    assign sr_Q = sr_reg;

    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] d,
                                             input logic [4:0] s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $unsigned($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        start   = 1'b1;
        op      = o;
        operand = d;
        shamt   = s;
    endtask

    // Waits for done (bounded), scrambling inputs and optionally pulsing start while busy.
    task automatic awaitResult(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                               input bit noise, input string tag);
        int          cyc;
        int          exp_lat;
        int          n_load;
        int          n_shift;
        int          n_bad;
        int          n_idle;
        int          exp_shifts;
        bit          seen;
        logic [1:0]  mode;
        cyc        = 0;
        n_load     = 0;
        n_shift    = 0;
        n_bad      = 0;
        n_idle     = 0;
        seen       = 1'b0;
        exp_lat    = int'(s) + 3;
        exp_shifts = (o == 2'b11) ? 0 : int'(s);
        mode       = (o == 2'b00) ? 2'b01 : 2'b10;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (sr_S == 2'b11) n_load++;
                else if (o != 2'b11 && sr_S == mode) n_shift++;
                else if (sr_S != 2'b00) n_bad++;
                if (!busy) n_idle++;
                op      = 2'($urandom_range(0, 3));
                operand = $urandom;
                shamt   = 5'($urandom_range(0, 31));
                if (noise && cyc < exp_lat) start = 1'($urandom_range(0, 1));
            end
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        checkOutput({tag, "_result"}, result, refShift(o, d, s));
        checkOutput({tag, "_loads"}, 32'(n_load), 32'd1);
        checkOutput({tag, "_shifts"}, 32'(n_shift), 32'(exp_shifts));
        checkOutput({tag, "_badmode"}, 32'(n_bad), 32'd0);
        checkOutput({tag, "_busy"}, 32'(n_idle), 32'd0);
    endtask

    task automatic checkQuiet(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_once"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_d;
        logic [4:0]  r_s;
        bit          saw_done;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        operand  = '0;
        shamt    = '0;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_sr_S", 32'(sr_S), 32'd0);
        checkOutput("reset_sr_bit", 32'(sr_bit), 32'd0);
        checkOutput("reset_sr_I", sr_I, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2'b00, 32'h0000_0001, 5'd4);
        awaitResult(2'b00, 32'h0000_0001, 5'd4, 1'b0, "sll4");
        checkOutput("sll4_value", result, 32'h0000_0010);
        checkQuiet("sll4");

        applyStimulus(2'b10, 32'h8000_0000, 5'd31);
        awaitResult(2'b10, 32'h8000_0000, 5'd31, 1'b0, "sra31");
        checkOutput("sra31_value", result, 32'hFFFF_FFFF);
        checkQuiet("sra31");

        applyStimulus(2'b01, 32'h8000_0000, 5'd31);
        awaitResult(2'b01, 32'h8000_0000, 5'd31, 1'b0, "srl31");
        checkOutput("srl31_value", result, 32'h0000_0001);
        checkQuiet("srl31");

        applyStimulus(2'b10, 32'hDEAD_BEEF, 5'd0);
        awaitResult(2'b10, 32'hDEAD_BEEF, 5'd0, 1'b0, "sra0");
        checkOutput("sra0_value", result, 32'hDEAD_BEEF);
        checkQuiet("sra0");

        applyStimulus(2'b01, 32'hF000_0000, 5'd8);
        awaitResult(2'b01, 32'hF000_0000, 5'd8, 1'b1, "b2b_first");
        checkOutput("b2b_first_value", result, 32'h00F0_0000);
        applyStimulus(2'b00, 32'h0000_0001, 5'd1);
        awaitResult(2'b00, 32'h0000_0001, 5'd1, 1'b1, "b2b_second");
        checkOutput("b2b_second_value", result, 32'h0000_0002);
        checkQuiet("b2b_second");

        applyStimulus(2'b00, 32'h0000_0001, 5'd20);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_sr_S", 32'(sr_S), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("midrst_no_done", 32'(saw_done), 32'd0);
        applyStimulus(2'b10, 32'h8000_00F0, 5'd4);
        awaitResult(2'b10, 32'h8000_00F0, 5'd4, 1'b0, "post_rst");
        checkOutput("post_rst_value", result, 32'hF800_000F);
        checkQuiet("post_rst");

        for (int i = 0; i < 25; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_d  = $urandom;
            r_s  = 5'($urandom_range(0, 31));
            applyStimulus(r_op, r_d, r_s);
            awaitResult(r_op, r_d, r_s, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0) checkQuiet($sformatf("rand%0d", i));
        end
        checkQuiet("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
